// File: rtl/i_ddr_deser_pkg.sv
// Shared types and elaboration helpers for the DDR input deserializer.
package i_ddr_deser_pkg;

    typedef enum logic [1:0] {
        StFill,
        StRun,
        StSlip
    } state_e;

    localparam int unsigned MinWidth = 4;
    localparam int unsigned MaxWidth = 16;

    function automatic bit width_legal(input int unsigned width);
        return (width >= MinWidth) && (width <= MaxWidth) && ((width % 2) == 0);
    endfunction

    // Bit counter must reach WIDTH+1 when a word ends on the rising half of a pair.
    function automatic int unsigned pair_cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/i_ddr_capture.sv
// DDR pin capture: rising and falling samples presented as one aligned pair per posedge.
module i_ddr_capture (
    input  logic       rst,
    input  logic       CLK,
    input  logic       D,
    input  logic       E,
    output logic [1:0] pair,
    output logic       pair_valid
);

    logic rise_q;
    logic fall_q;
    logic valid_q;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rise_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= E;
            if (E) begin
                rise_q <= D;
            end
        end
    end

    // The falling sample belongs to the pair opened by the preceding enabled rising sample.
    always_ff @(negedge CLK or negedge rst) begin
        if (!rst) begin
            fall_q <= 1'b0;
        end else if (valid_q) begin
            fall_q <= D;
        end
    end

    assign pair       = {fall_q, rise_q};
    assign pair_valid = valid_q;

endmodule

// File: rtl/i_ddr_deser.sv
// DDR input deserializer: gearbox from bit pairs to WIDTH-bit words with bitslip framing.
module i_ddr_deser
    import i_ddr_deser_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SLIP_DISCARD = 1
) (
    input  logic             rst,
    input  logic             CLK,
    input  logic             D,
    input  logic             E,
    input  logic             BITSLIP,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    output logic             SLIP_BUSY
);

    localparam int unsigned CntW = pair_cnt_width(WIDTH);
    localparam int unsigned OffW = CntW - 1;

    localparam logic [CntW-1:0] WidthC = CntW'(WIDTH);
    localparam logic [CntW-1:0] TwoC   = CntW'(2);
    localparam logic [OffW-1:0] OffMax = OffW'(WIDTH - 1);
    localparam logic [1:0]      DiscC  = 2'(SLIP_DISCARD);

    if (!width_legal(WIDTH) || (SLIP_DISCARD < 1) || (SLIP_DISCARD > 2)) begin : g_param_check
        $error("i_ddr_deser: illegal WIDTH or SLIP_DISCARD");
    end

    logic [1:0] pair;
    logic       pair_valid;

    i_ddr_capture u_capture (
        .rst       (rst),
        .CLK       (CLK),
        .D         (D),
        .E         (E),
        .pair      (pair),
        .pair_valid(pair_valid)
    );

    state_e           state_q, state_d;
    logic [OffW-1:0]  s_q, s_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic [1:0]       disc_q, disc_d;
    logic             pend_q, pend_d;

    logic [WIDTH:0]   shifted;
    logic [CntW-1:0]  sum;
    logic             accept;
    logic             consume;
    logic             done;
    logic [WIDTH-1:0] word;

    // Oldest bit at index 0; the newest pair sits on top of the WIDTH-1 retained bits.
    assign shifted = {pair, sr_q};

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        disc_d    = disc_q;
        pend_d    = pend_q;
        accept    = 1'b0;
        consume   = 1'b0;
        done      = 1'b0;
        sum       = cnt_q;
        word      = shifted[WIDTH:1];

        if (!E) begin
            state_d = StFill;
            pend_d  = 1'b0;
            // Preload so the first (discarded) word ends s bits into the restarted stream.
            cnt_d   = (s_q == '0) ? '0 : (WidthC - {1'b0, s_q});
        end else begin
            accept  = BITSLIP && (state_q == StRun) && pair_valid;
            consume = (state_q == StSlip) && pend_q && pair_valid;

            if (pair_valid) begin
                sr_d = shifted[WIDTH:2];
                sum  = cnt_q + TwoC - {{(CntW - 1){1'b0}}, consume};
                if (sum >= WidthC) begin
                    done  = 1'b1;
                    cnt_d = sum - WidthC;
                    // sum == WIDTH+1 means the word closed on the rising half of this pair.
                    word  = (sum == WidthC) ? shifted[WIDTH:1] : shifted[WIDTH-1:0];
                end else begin
                    cnt_d = sum;
                end
            end

            if (consume) begin
                pend_d = 1'b0;
            end

            if (done) begin
                unique case (state_q)
                    StFill: state_d = StRun;
                    StRun: begin
                        q_d       = word;
                        q_valid_d = 1'b1;
                    end
                    StSlip: begin
                        if (disc_q == 2'd1) begin
                            state_d = StRun;
                        end else begin
                            disc_d = disc_q - 2'd1;
                        end
                    end
                    default: state_d = StFill;
                endcase
            end

            if (accept) begin
                state_d = StSlip;
                disc_d  = DiscC;
                pend_d  = 1'b1;
                s_d     = (s_q == OffMax) ? '0 : (s_q + OffW'(1));
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= StFill;
            s_q       <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            disc_q    <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            disc_q    <= disc_d;
            pend_q    <= pend_d;
        end
    end

    assign Q         = q_q;
    assign Q_VALID   = q_valid_q;
    assign SLIP_BUSY = (state_q == StSlip);

endmodule

// File: tb/tb_i_ddr_deser.sv
// Randomized and directed bench for i_ddr_deser against a bit-position reference model.
module tb_i_ddr_deser;

    localparam int unsigned W  = 8;
    localparam int unsigned SD = 1;

    logic         rst;
    logic         CLK;
    logic         D;
    logic         E;
    logic         BITSLIP;
    logic [W-1:0] Q;
    logic         Q_VALID;
    logic         SLIP_BUSY;

    i_ddr_deser #(
        .WIDTH       (W),
        .SLIP_DISCARD(SD)
    ) dut (
        .rst      (rst),
        .CLK      (CLK),
        .D        (D),
        .E        (E),
        .BITSLIP  (BITSLIP),
        .Q        (Q),
        .Q_VALID  (Q_VALID),
        .SLIP_BUSY(SLIP_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: absolute bit positions since the last restart.
    bit           m_b[$];
    int           m_next_end;
    int           m_s;
    int           m_mode;  // 0 fill, 1 run, 2 slip
    int           m_disc;
    bit           m_pend;
    bit           m_have;
    bit           m_rise;
    bit           m_fall;
    logic [W-1:0] m_q;
    bit           m_qv;

    // Stimulus source
    logic [7:0] pat = 8'hA5;
    bit         use_pat = 1'b1;
    int         pat_off = 0;
    int         sidx = 0;

    function automatic void model_restart();
        m_b.delete();
        m_next_end = (m_s == 0) ? (W - 1) : (m_s - 1);
        m_mode     = 0;
        m_pend     = 1'b0;
    endfunction

    function automatic void model_reset();
        m_s    = 0;
        m_q    = '0;
        m_qv   = 1'b0;
        m_have = 1'b0;
        m_disc = 0;
        sidx   = 0;
        model_restart();
    endfunction

    function automatic void model_step(input bit e, input bit bs);
        int start_mode;
        bit acc;
        m_qv = 1'b0;
        if (!e) begin
            model_restart();
            return;
        end
        start_mode = m_mode;
        acc = bs && (start_mode == 1) && m_have;
        if ((start_mode == 2) && m_pend && m_have) begin
            m_next_end++;
            m_pend = 1'b0;
        end
        if (m_have) begin
            m_b.push_back(m_rise);
            m_b.push_back(m_fall);
            if (m_next_end <= int'(m_b.size()) - 1) begin
                if (start_mode == 1) begin
                    for (int i = 0; i < W; i++) m_q[i] = m_b[m_next_end - W + 1 + i];
                    m_qv = 1'b1;
                end else if (start_mode == 2) begin
                    m_disc--;
                    if (m_disc == 0) m_mode = 1;
                end else begin
                    m_mode = 1;
                end
                m_next_end += W;
            end
        end
        if (acc) begin
            m_s    = (m_s + 1) % W;
            m_mode = 2;
            m_disc = SD;
            m_pend = 1'b1;
        end
    endfunction

    function automatic bit stream_bit(input int idx);
        return pat[(idx + pat_off) % 8];
    endfunction

    // Called at negedge+1; returns at the following negedge+1.
    task automatic cycle(input bit e, input bit bs);
        bit r;
        bit f;
        if (e && use_pat) begin
            r = stream_bit(sidx);
            f = stream_bit(sidx + 1);
        end else begin
            r = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
        end
        sidx    = e ? (sidx + 2) : 0;
        E       = e;
        BITSLIP = bs;
        D       = r;
        @(posedge CLK);
        #1;
        model_step(e, bs);
        check_val("q", 32'(Q), 32'(m_q));
        check_val("q_valid", 32'(Q_VALID), 32'(m_qv));
        check_val("slip_busy", 32'(SLIP_BUSY), 32'(m_mode == 2));
        m_rise  = r;
        m_fall  = f;
        m_have  = e;
        BITSLIP = 1'b0;
        D       = f;
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        D   = ~D;
        rst = 1'b0;
        #1;
        check_val("rst_q", 32'(Q), 32'h0);
        check_val("rst_q_valid", 32'(Q_VALID), 32'h0);
        check_val("rst_slip_busy", 32'(SLIP_BUSY), 32'h0);
        model_reset();
        @(posedge CLK);
        D = ~D;
        @(negedge CLK);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (SLIP_BUSY && n < 20) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        check_val(tag, 32'(SLIP_BUSY), 32'h0);
    endtask

    task automatic wait_valid(input string tag, input logic [7:0] exp);
        int n = 0;
        do begin
            cycle(1'b1, 1'b0);
            n++;
        end while (!Q_VALID && n < 40);
        check_val({tag, "_vld"}, 32'(Q_VALID), 32'h1);
        check_val(tag, 32'(Q), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        rst     = 1'b0;
        E       = 1'b0;
        BITSLIP = 1'b0;
        D       = 1'b0;
        #12;
        check_val("init_q", 32'(Q), 32'h0);
        check_val("init_q_valid", 32'(Q_VALID), 32'h0);
        check_val("init_slip_busy", 32'(SLIP_BUSY), 32'h0);
        model_reset();
        rst = 1'b1;

        // Aligned 0xA5 stream
        pat_off = 0;
        wait_valid("aligned", 8'hA5);
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0);
            if (Q_VALID) nv++;
        end
        check_val("valid_rate", 32'(nv), 32'd4);

        // Three-bit offset, then alignment search
        pat_off = 5;
        cycle(1'b0, 1'b0);
        wait_valid("rotated", 8'h2D);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1);
            check_val("search_busy", 32'(SLIP_BUSY), 32'h1);
            wait_idle("search_idle");
        end
        wait_valid("searched", 8'hA5);

        // Full wrap with redundant pulses while busy
        for (int k = 0; k < W; k++) begin
            cycle(1'b1, 1'b1);
            cycle(1'b1, 1'b1);
            wait_idle("wrap_idle");
        end
        wait_valid("wrapped", 8'hA5);

        // Enable gating mid-word
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0);
            check_val("gate_no_valid", 32'(Q_VALID), 32'h0);
            check_val("gate_hold", 32'(Q), 32'hA5);
        end
        wait_valid("restart", 8'hA5);

        // E low together with BITSLIP drops the slip
        cycle(1'b0, 1'b1);
        wait_valid("e_wins", 8'hA5);

        // Reset during a slip
        cycle(1'b1, 1'b1);
        check_val("slip_before_rst", 32'(SLIP_BUSY), 32'h1);
        pat_off = 0;
        do_reset();
        wait_valid("post_reset", 8'hA5);

        // Randomized traffic
        use_pat = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if (i % 300 == 299) begin
                do_reset();
            end else begin
                cycle(bit'($urandom_range(0, 11) != 0), bit'($urandom_range(0, 5) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
